// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared FSM states and fetch constants for the instruction fetch unit
package inst_fetch_unit_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   // addi x0, x0, 0 : the canonical RISC-V no-op
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // sequential instructions are one 32-bit word apart
   localparam logic [63:0] PC_INCR = 64'd4;

endpackage

// File: rtl/inst_fetch_unit_pc_next_calc.sv
// rtl/inst_fetch_unit_pc_next_calc.sv - combinational next-pc selection and alignment check
module pc_next_calc (
   input  logic [63:0] pc,
   input  logic        branch_taken,
   input  logic [63:0] branch_offset,
   output logic [63:0] next_pc,
   output logic        misalign
);

   import inst_fetch_unit_pkg::*;

   // 64-bit adds wrap naturally at 2^64; any target off a word boundary is flagged
   always_comb begin
      next_pc  = branch_taken ? (pc + branch_offset) : (pc + PC_INCR);
      misalign = |next_pc[1:0];
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - single-outstanding instruction fetch FSM with timeout and alignment fault
module inst_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        branch_taken,
   input  logic [63:0] branch_offset,
   input  logic        core_ready,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [63:0] pc,
   output logic        fault
);

   import inst_fetch_unit_pkg::*;

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t          state;
   logic [CW-1:0]   wait_cnt;
   logic [63:0]     next_pc;
   logic            misalign;

   // branch inputs feed the calculator freely; only the accept cycle consumes its result
   pc_next_calc u_pc_next_calc (
      .pc            (pc),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .next_pc       (next_pc),
      .misalign      (misalign)
   );

   assign imem_addr = pc;

   // fetch sequencing: one request in flight, all outputs registered alongside the state
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         pc         <= RESET_PC;
         inst       <= NOP_INST;
         inst_valid <= 1'b0;
         imem_req   <= 1'b0;
         fault      <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_FETCH;
                  imem_req <= 1'b1;
               end
            end
            ST_FETCH: begin
               // address is pc, which does not move until the request is granted
               if (imem_gnt) begin
                  state    <= ST_WAIT;
                  imem_req <= 1'b0;
                  wait_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  inst       <= imem_rdata;
                  inst_valid <= 1'b1;
                  state      <= ST_ISSUE;
                  wait_cnt   <= '0;
               end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  wait_cnt <= wait_cnt + CW'(1);
                  state    <= ST_FAULT;
                  fault    <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            ST_ISSUE: begin
               if (core_ready) begin
                  inst_valid <= 1'b0;
                  pc         <= next_pc;
                  if (misalign) begin
                     // pc keeps the bad target so software can see where it went wrong
                     state <= ST_FAULT;
                     fault <= 1'b1;
                  end else if (start) begin
                     state    <= ST_FETCH;
                     imem_req <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_FAULT: begin
               // terminal until reset; everything else stays as it was
            end
            default: begin
               state      <= ST_FAULT;
               fault      <= 1'b1;
               imem_req   <= 1'b0;
               inst_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
